// File: rtl/vram_write_sched_if.sv
// Bundle of CPU write port, HDMI timing inputs and picture-memory write strobes
// for vram_write_sched; slave = the scheduler, master = the CPU/video side.
interface vram_write_sched_if #(
   parameter int FIFO_DEPTH = 4
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic             cpu_req;
   logic [15:0]      cpu_addr;
   logic [11:0]      cpu_data;
   logic             cpu_ready;
   logic             vid_de;
   logic             vid_vs;
   logic             wr_tile_en;
   logic [13:0]      wr_tile_addr;
   logic [3:0]       wr_tile_data;
   logic             wr_map_en;
   logic [8:0]       wr_map_addr;
   logic [5:0]       wr_map_data;
   logic             wr_pal_en;
   logic [3:0]       wr_pal_addr;
   logic [11:0]      wr_pal_data;
   logic             err;
   logic [CNT_W-1:0] pending;
   logic [7:0]       frame_cnt;

   modport master (
      output cpu_req, cpu_addr, cpu_data, vid_de, vid_vs,
      input  cpu_ready, wr_tile_en, wr_tile_addr, wr_tile_data,
             wr_map_en, wr_map_addr, wr_map_data,
             wr_pal_en, wr_pal_addr, wr_pal_data, err, pending, frame_cnt
   );

   modport slave (
      input  cpu_req, cpu_addr, cpu_data, vid_de, vid_vs,
      output cpu_ready, wr_tile_en, wr_tile_addr, wr_tile_data,
             wr_map_en, wr_map_addr, wr_map_data,
             wr_pal_en, wr_pal_addr, wr_pal_data, err, pending, frame_cnt
   );
endinterface

// File: rtl/vram_write_sched.sv
// Buffers CPU writes to palette / tile definitions / tile map and commits one per clock.
// Define VRAM_BLANK_ONLY_EN to restrict commits to blanking (vid_de = 0).
module vram_write_sched #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              resetn,
   vram_write_sched_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_HOLD  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam logic [1:0] RG_TILE = 2'd0;
   localparam logic [1:0] RG_MAP  = 2'd1;
   localparam logic [1:0] RG_PAL  = 2'd2;
   localparam logic [1:0] RG_MISS = 2'd3;

   typedef struct packed {
      logic [1:0]  region;
      logic [13:0] addr;
      logic [11:0] data;
   } entry_t;

   entry_t           fifo_q [FIFO_DEPTH];
   entry_t           fifo_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       state_q, state_d;
   logic             tile_en_q, tile_en_d, map_en_q, map_en_d, pal_en_q, pal_en_d;
   logic [13:0]      tile_addr_q, tile_addr_d;
   logic [3:0]       tile_data_q, tile_data_d;
   logic [8:0]       map_addr_q, map_addr_d;
   logic [5:0]       map_data_q, map_data_d;
   logic [3:0]       pal_addr_q, pal_addr_d;
   logic [11:0]      pal_data_q, pal_data_d;
   logic             err_q, err_d, vs_q, vs_d;
   logic [7:0]       frame_q, frame_d;

   logic   permit, ready, accept, push, pop;
   entry_t in_e, head;

`ifdef VRAM_BLANK_ONLY_EN
   assign permit = !bus.vid_de;
`else
   logic vid_de_unused;
   assign permit        = 1'b1;
   assign vid_de_unused = bus.vid_de;
`endif

   // Map window base 0x4000 has zero low bits, so the local index is addr[8:0].
   always_comb begin
      in_e        = '0;
      in_e.region = RG_MISS;
      if (bus.cpu_addr[15:14] == 2'b00) begin
         in_e.region = RG_TILE;
         in_e.addr   = bus.cpu_addr[13:0];
         in_e.data   = {8'h00, bus.cpu_data[3:0]};
      end else if (bus.cpu_addr >= 16'h4000 && bus.cpu_addr <= 16'h412B) begin
         in_e.region = RG_MAP;
         in_e.addr   = {5'd0, bus.cpu_addr[8:0]};
         in_e.data   = {6'h00, bus.cpu_data[5:0]};
      end else if (bus.cpu_addr[15:4] == 12'h420) begin
         in_e.region = RG_PAL;
         in_e.addr   = {10'd0, bus.cpu_addr[3:0]};
         in_e.data   = bus.cpu_data;
      end
   end

   assign ready  = (cnt_q != CNT_W'(FIFO_DEPTH));
   assign accept = bus.cpu_req && ready;
   assign push   = accept && (in_e.region != RG_MISS);
   assign pop    = (state_q != ST_IDLE) && permit;
   assign head   = fifo_q[rptr_q];

   always_comb begin
      fifo_d      = fifo_q;
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      tile_en_d   = 1'b0;
      map_en_d    = 1'b0;
      pal_en_d    = 1'b0;
      tile_addr_d = tile_addr_q;
      tile_data_d = tile_data_q;
      map_addr_d  = map_addr_q;
      map_data_d  = map_data_q;
      pal_addr_d  = pal_addr_q;
      pal_data_d  = pal_data_q;
      if (push) begin
         fifo_d[wptr_q] = in_e;
         wptr_d         = wptr_q + PTR_W'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + PTR_W'(1);
         case (head.region)
            RG_TILE: begin
               tile_en_d   = 1'b1;
               tile_addr_d = head.addr;
               tile_data_d = head.data[3:0];
            end
            RG_MAP: begin
               map_en_d   = 1'b1;
               map_addr_d = head.addr[8:0];
               map_data_d = head.data[5:0];
            end
            RG_PAL: begin
               pal_en_d   = 1'b1;
               pal_addr_d = head.addr[3:0];
               pal_data_d = head.data;
            end
            default: ;
         endcase
      end
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
      if (cnt_d == '0)  state_d = ST_IDLE;
      else if (permit)  state_d = ST_DRAIN;
      else              state_d = ST_HOLD;
      err_d   = accept && (in_e.region == RG_MISS);
      vs_d    = bus.vid_vs;
      frame_d = frame_q + 8'(bus.vid_vs && !vs_q);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         cnt_q       <= '0;
         state_q     <= ST_IDLE;
         tile_en_q   <= 1'b0;
         map_en_q    <= 1'b0;
         pal_en_q    <= 1'b0;
         tile_addr_q <= '0;
         tile_data_q <= '0;
         map_addr_q  <= '0;
         map_data_q  <= '0;
         pal_addr_q  <= '0;
         pal_data_q  <= '0;
         err_q       <= 1'b0;
         vs_q        <= 1'b0;
         frame_q     <= '0;
      end else begin
         fifo_q      <= fifo_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         cnt_q       <= cnt_d;
         state_q     <= state_d;
         tile_en_q   <= tile_en_d;
         map_en_q    <= map_en_d;
         pal_en_q    <= pal_en_d;
         tile_addr_q <= tile_addr_d;
         tile_data_q <= tile_data_d;
         map_addr_q  <= map_addr_d;
         map_data_q  <= map_data_d;
         pal_addr_q  <= pal_addr_d;
         pal_data_q  <= pal_data_d;
         err_q       <= err_d;
         vs_q        <= vs_d;
         frame_q     <= frame_d;
      end
   end

   assign bus.cpu_ready    = ready;
   assign bus.wr_tile_en   = tile_en_q;
   assign bus.wr_tile_addr = tile_addr_q;
   assign bus.wr_tile_data = tile_data_q;
   assign bus.wr_map_en    = map_en_q;
   assign bus.wr_map_addr  = map_addr_q;
   assign bus.wr_map_data  = map_data_q;
   assign bus.wr_pal_en    = pal_en_q;
   assign bus.wr_pal_addr  = pal_addr_q;
   assign bus.wr_pal_data  = pal_data_q;
   assign bus.err          = err_q;
   assign bus.pending      = cnt_q;
   assign bus.frame_cnt    = frame_q;
endmodule

// File: tb/tb_vram_write_sched.sv
// Randomized + directed bench for vram_write_sched against a queue-based reference model.
module tb_vram_write_sched;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   vram_write_sched_if #(.FIFO_DEPTH(DEPTH)) bus ();
   vram_write_sched #(.FIFO_DEPTH(DEPTH)) dut (.clk(clk), .resetn(resetn), .bus(bus));

   // region: 0 tiledef, 1 tilemap, 2 palette, 3 miss
   typedef struct { int region; int addr; int data; } wr_t;

   wr_t mq[$];
   int  m_en[3], m_addr[3], m_data[3];
   int  m_err, m_frame;
   bit  m_prev_vs;
   int  errors = 0, checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit permitted();
`ifdef VRAM_BLANK_ONLY_EN
      return !bus.vid_de;
`else
      return 1'b1;
`endif
   endfunction

   function automatic wr_t decode(input int a, input int d);
      wr_t w;
      w.region = 3; w.addr = 0; w.data = 0;
      if (a < 'h4000) begin
         w.region = 0; w.addr = a; w.data = d % 16;
      end else if (a <= 'h412B) begin
         w.region = 1; w.addr = a - 'h4000; w.data = d % 64;
      end else if (a >= 'h4200 && a <= 'h420F) begin
         w.region = 2; w.addr = a - 'h4200; w.data = d;
      end
      return w;
   endfunction

   task automatic model_reset();
      mq.delete();
      for (int r = 0; r < 3; r++) begin m_en[r] = 0; m_addr[r] = 0; m_data[r] = 0; end
      m_err = 0; m_frame = 0; m_prev_vs = 1'b0;
   endtask

   task automatic model_edge();
      wr_t w;
      bit  acc;
      if (!resetn) begin model_reset(); return; end
      acc = bus.cpu_req && (mq.size() < DEPTH);
      for (int r = 0; r < 3; r++) m_en[r] = 0;
      if (permitted() && mq.size() > 0) begin
         w = mq.pop_front();
         m_en[w.region] = 1; m_addr[w.region] = w.addr; m_data[w.region] = w.data;
      end
      m_err = 0;
      if (acc) begin
         w = decode(int'(bus.cpu_addr), int'(bus.cpu_data));
         if (w.region == 3) m_err = 1;
         else mq.push_back(w);
      end
      if (bus.vid_vs && !m_prev_vs) m_frame = (m_frame + 1) % 256;
      m_prev_vs = bus.vid_vs;
   endtask

   task automatic check_all();
      chk("pending",   32'(bus.pending), mq.size());
      chk("cpu_ready", 32'(bus.cpu_ready), 32'(mq.size() < DEPTH));
      chk("err",       32'(bus.err), m_err);
      chk("tile_en",   32'(bus.wr_tile_en), m_en[0]);
      chk("tile_addr", 32'(bus.wr_tile_addr), m_addr[0]);
      chk("tile_data", 32'(bus.wr_tile_data), m_data[0]);
      chk("map_en",    32'(bus.wr_map_en), m_en[1]);
      chk("map_addr",  32'(bus.wr_map_addr), m_addr[1]);
      chk("map_data",  32'(bus.wr_map_data), m_data[1]);
      chk("pal_en",    32'(bus.wr_pal_en), m_en[2]);
      chk("pal_addr",  32'(bus.wr_pal_addr), m_addr[2]);
      chk("pal_data",  32'(bus.wr_pal_data), m_data[2]);
      chk("frame_cnt", 32'(bus.frame_cnt), m_frame);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic put(input bit req, input int a, input int d);
      bus.cpu_req  = req;
      bus.cpu_addr = 16'(a);
      bus.cpu_data = 12'(d);
   endtask

   function automatic int rand_addr();
      int miss_tab[6];
      miss_tab = '{'h412C, 'h41FF, 'h4210, 'h4300, 'h8000, 'hFFFF};
      case ($urandom_range(0, 5))
         0, 1:    return int'($urandom_range(0, 'h3FFF));
         2:       return 'h4000 + int'($urandom_range(0, 299));
         3, 4:    return 'h4200 + int'($urandom_range(0, 15));
         default: return miss_tab[$urandom_range(0, 5)];
      endcase
   endfunction

   initial begin
      model_reset();
      put(0, 0, 0);
      bus.vid_de = 1'b0;
      bus.vid_vs = 1'b0;

      // reset state
      step(); step();
      chk("rst_ready", 32'(bus.cpu_ready), 1);
      chk("rst_pending", 32'(bus.pending), 0);
      resetn = 1'b1;
      step();

      // palette write with permission
      put(1, 'h4203, 'hF0A);
      step();
      put(0, 0, 0);
      step();
      chk("pal_dir_en", 32'(bus.wr_pal_en), 1);
      chk("pal_dir_addr", 32'(bus.wr_pal_addr), 3);
      chk("pal_dir_data", 32'(bus.wr_pal_data), 'hF0A);
      chk("pal_dir_pend", 32'(bus.pending), 0);
      step();
      chk("pal_dir_once", 32'(bus.wr_pal_en), 0);

      // decode misses
      put(1, 'h4300, 'h123);
      step();
      chk("miss_4300", 32'(bus.err), 1);
      put(1, 'h412C, 'h05);
      step();
      chk("miss_412c", 32'(bus.err), 1);
      chk("miss_pend", 32'(bus.pending), 0);
      put(0, 0, 0);
      step();
      chk("miss_clear", 32'(bus.err), 0);

      // fill during active video, then drain in blanking
      bus.vid_de = 1'b1;
      for (int i = 0; i < 5; i++) begin
         put(1, 'h4200 + i, 'h111 * (i + 1));
         step();
      end
`ifdef VRAM_BLANK_ONLY_EN
      chk("full_pend", 32'(bus.pending), 4);
      chk("full_ready", 32'(bus.cpu_ready), 0);
`endif
      bus.vid_de = 1'b0;
      step(); step();
      put(0, 0, 0);
      for (int i = 0; i < 5; i++) step();
      chk("fill_drained", 32'(bus.pending), 0);

      // back-to-back tiledef then tilemap
      put(1, 'h0000, 'h7);
      step();
      put(1, 'h412B, 'h3F);
      step();
      chk("b2b_tile_en", 32'(bus.wr_tile_en), 1);
      chk("b2b_pend", 32'(bus.pending), 1);
      put(0, 0, 0);
      step();
      chk("b2b_map_en", 32'(bus.wr_map_en), 1);
      chk("b2b_tile_off", 32'(bus.wr_tile_en), 0);
      chk("b2b_map_addr", 32'(bus.wr_map_addr), 299);
      chk("b2b_map_data", 32'(bus.wr_map_data), 'h3F);

      // reset mid-operation
`ifdef VRAM_BLANK_ONLY_EN
      bus.vid_de = 1'b1;
`endif
      for (int i = 0; i < 3; i++) begin
         put(1, 'h0100 + i, i + 1);
         step();
      end
      put(0, 0, 0);
`ifdef VRAM_BLANK_ONLY_EN
      chk("pre_rst_pend", 32'(bus.pending), 3);
`endif
      #3 resetn = 1'b0;
      #1;
      model_reset();
      chk("arst_tile_en", 32'(bus.wr_tile_en), 0);
      chk("arst_pend", 32'(bus.pending), 0);
      chk("arst_ready", 32'(bus.cpu_ready), 1);
      step(); step();
      resetn = 1'b1;
      bus.vid_de = 1'b0;
      for (int i = 0; i < 4; i++) step();

      // frame counter wrap
      for (int i = 0; i < 257; i++) begin
         bus.vid_vs = 1'b1; step();
         bus.vid_vs = 1'b0; step();
      end
      chk("frame_257", 32'(bus.frame_cnt), 1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) bus.vid_de = ~bus.vid_de;
         bus.vid_vs = ($urandom_range(0, 19) == 0);
         put($urandom_range(0, 9) < 7, rand_addr(), int'($urandom_range(0, 'hFFF)));
         step();
      end
      put(0, 0, 0);
      bus.vid_de = 1'b0;
      for (int i = 0; i < 8; i++) step();
      chk("final_pend", 32'(bus.pending), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/vram_write_sched.md
# vram_write_sched

Write scheduler for the video picture memories: palette (16×12 bit), tile definitions (16384×4 bit) and tile map (300×6 bit). It takes a single CPU-side write stream, decodes the address into a memory region, buffers the writes in a small FIFO and commits them one per clock on dedicated per-memory write strobes. Commits can be restricted to blanking so the picture never tears. It sits between the CPU bus and the video block's picture memories and runs in the system clock domain.

## Interface
- FIFO_DEPTH, 4, write buffer entries; power of two, ≥2
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- cpu_req  in  1  write request valid
- cpu_addr  in  16  write address (decode below)
- cpu_data  in  12  write data; low bits used per region
- cpu_ready  out  1  write accepted on edge where cpu_req && cpu_ready
- vid_de  in  1  active video from HDMI timing (1 = visible pixel)
- vid_vs  in  1  vertical sync from HDMI timing, active high
- wr_tile_en  out  1  tile definition write strobe
- wr_tile_addr  out  14  tile definition index
- wr_tile_data  out  4  palette index
- wr_map_en  out  1  tile map write strobe
- wr_map_addr  out  9  tile map index, 0..299
- wr_map_data  out  6  tile number
- wr_pal_en  out  1  palette write strobe
- wr_pal_addr  out  4  palette index
- wr_pal_data  out  12  RGB444 colour {r,g,b}
- err  out  1  one-cycle pulse: decode miss
- pending  out  $clog2(FIFO_DEPTH)+1  entries in FIFO
- frame_cnt  out  8  vid_vs rising-edge count

## Operation
- Decode on acceptance: 0x0000–0x3FFF tiledef (addr[13:0], data[3:0]); 0x4000–0x412B tilemap (addr−0x4000, data[5:0]); 0x4200–0x420F palette (addr[3:0], data[11:0]); anything else is a miss.
- Miss: accepted (cpu_ready rules unchanged), not enqueued, err high one cycle after acceptance edge.
- FIFO entry = region (2 bit) + local address + masked data. cpu_ready = !full (registered-full, no same-cycle pop bypass).
- States: IDLE (FIFO empty, strobes low); HOLD (non-empty, commit not allowed); DRAIN (non-empty, commit allowed: pop head each cycle, drive its region strobe).
- Transitions: IDLE→HOLD/DRAIN on first push; DRAIN→HOLD when commit permission drops; HOLD→DRAIN when it returns; DRAIN→IDLE when last entry pops and no push that edge.
- Commit permission: see Configuration.
- Exactly one wr_*_en high per commit cycle; never two at once. Address/data outputs hold last committed value when strobes low.
- Simultaneous push and pop: both occur, pending unchanged.
- frame_cnt: increments on vid_vs 0→1 (one-cycle edge detect, registered), wraps 255→0.

## Timing
- Reset (async assert, sync-release behaviour from flops): cpu_ready 1, all wr_*_en 0, all wr addr/data 0, err 0, pending 0, frame_cnt 0, state IDLE. Mid-operation reset discards all pending writes; no partial strobe after release.
- Latency: write accepted at edge N with permission → strobe high for cycle N+1..N+2. With FIFO already holding k entries: strobe at N+1+k.
- Permission sampled on vid_de registered at the same edge that loads the strobe; a commit may land in the first active pixel cycle after blanking ends (one-cycle skid, accepted).
- Throughput: 1 write/clock sustained while permitted.
- pending, cpu_ready update on the acceptance/pop edge.

## Configuration
- VRAM_BLANK_ONLY_EN defined: commit permitted only when vid_de = 0; during active video FIFO fills, cpu_ready drops when full.
- Not defined: commit permitted every cycle; vid_de ignored; HOLD unreachable.

## Test plan
- Palette write 0x4203←0xF0A, permission true → wr_pal_en one cycle, wr_pal_addr 3, wr_pal_data 0xF0A, one cycle after acceptance; pending returns 0.
- Miss 0x4300 and 0x412C → err pulse each, no strobes, pending stays 0.
- With VRAM_BLANK_ONLY_EN, vid_de=1, push 5 writes (depth 4) → 4 accepted, cpu_ready 0 on 5th, pending 4; drop vid_de → 4 strobes on consecutive cycles in push order, 5th accepted.
- Back-to-back tiledef 0x0000←0x7 and tilemap 0x412B←0x3F streaming with permission → wr_tile_en then wr_map_en (addr 299, data 0x3F), never overlapping, pending constant during overlap.
- resetn low while FIFO holds 3 entries → immediate strobes low, pending 0, no commits after release.
- Toggle vid_vs 257 times → frame_cnt = 1.
